// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM stream sequencer: default geometry and FSM states.
package rom_stream_pkg;

    localparam int unsigned ROM_DEPTH  = 256;
    localparam int unsigned ROM_DATA_W = 32;
    localparam int unsigned ROM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

endpackage

// File: rtl/rom_stream_ctrl.sv
// Walks a base/length window of an external combinational ROM and streams the
// words out over valid/ready, optionally looping the window without bubbles.
module rom_stream_ctrl
    import rom_stream_pkg::*;
#(
    parameter int unsigned DATA_W = ROM_DATA_W,
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DEPTH  = ROM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pass_cnt
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] base_lat;
    logic [ADDR_W-1:0] num_lat;
    logic              loop_lat;
    logic [ADDR_W-1:0] remaining;
    logic              out_last;

    logic [ADDR_W-1:0] base_mod;
    logic [ADDR_W-1:0] addr_inc;
    logic              slot_free;

    always_comb begin
        base_mod  = base_addr % DEPTH_A;
        addr_inc  = (cur_addr == LAST_A) ? '0 : cur_addr + 1'b1;
        slot_free = !out_valid || out_ready;
    end

    assign rom_addr = cur_addr;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            base_lat  <= '0;
            num_lat   <= '0;
            loop_lat  <= 1'b0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            pass_cnt  <= '0;
        end else if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_lat  <= base_mod;
                        num_lat   <= num_words;
                        loop_lat  <= loop;
                        cur_addr  <= base_mod;
                        remaining <= num_words;
                        pass_cnt  <= '0;
                        state     <= (num_words == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    // out_last tags the final word of a pass so the count
                    // advances on its acceptance, not on its load.
                    if (out_valid && out_ready && out_last && pass_cnt != '1) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                    if (slot_free) begin
                        if (remaining != '0) begin
                            out_data  <= rom_data;
                            out_valid <= 1'b1;
                            out_last  <= (remaining == ONE_A);
                            if (remaining == ONE_A && loop_lat) begin
                                cur_addr  <= base_lat;
                                remaining <= num_lat;
                            end else begin
                                cur_addr  <= addr_inc;
                                remaining <= remaining - 1'b1;
                            end
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (!loop_lat) begin
                                state <= FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Bench for rom_stream_ctrl: ROM model, window-level reference model checked
// every cycle, directed scenarios with literal expectations, then random runs.
module tb_rom_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, loop, out_ready;
    logic [15:0] base_addr, num_words, rom_addr;
    logic [31:0] rom_data, out_data;
    logic        out_valid, busy, done;
    logic [15:0] pass_cnt;

    logic [31:0] mem [256];
    assign rom_data = mem[rom_addr[7:0]];

    always #5 clk = ~clk;

    rom_stream_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .loop      (loop),
        .base_addr (base_addr),
        .num_words (num_words),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model of the current run: window, words accepted, completion timestamps
    bit m_active = 1'b0;
    bit m_loop   = 1'b0;
    bit m_rstchk = 1'b1;
    int m_base   = 0;
    int m_n      = 0;
    int m_k      = 0;
    int m_start  = 0;
    int m_fin    = -10;
    int m_done   = -10;
    int m_pcnt   = 0;

    logic [31:0] acc_q[$];
    int          dcount = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit vexp;
        int loaded;
        int widx;
        vexp = m_active && (cyc >= m_start + 1) && (m_loop || m_k < m_n);
        chk("out_valid", out_valid, vexp);
        chk("busy", busy, m_active || (m_fin == cyc));
        chk("done", done, m_done == cyc);
        chk("pass_cnt", pass_cnt, m_pcnt);
        if (vexp) begin
            widx = m_loop ? (m_k % m_n) : m_k;
            chk("out_data", out_data, mem[(m_base + widx) % 256]);
        end
        if (m_active) begin
            loaded = m_k + (vexp ? 1 : 0);
            if (m_loop) loaded = loaded % m_n;
            chk("rom_addr", rom_addr, (m_base + loaded) % 256);
        end
        if (m_rstchk) begin
            chk("reset out_data", out_data, 0);
            chk("reset rom_addr", rom_addr, 0);
        end
        if (out_valid && out_ready) acc_q.push_back(out_data);
        if (done) dcount++;

        m_rstchk = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_pcnt   = 0;
            m_fin    = -10;
            m_done   = -10;
            m_rstchk = 1'b1;
        end else if (abort) begin
            m_active = 1'b0;
            m_fin    = -10;
            m_done   = -10;
        end else if (vexp && out_ready) begin
            m_k++;
            if (m_k % m_n == 0 && m_pcnt < 65535) m_pcnt++;
            if (!m_loop && m_k == m_n) begin
                m_active = 1'b0;
                m_fin    = cyc + 1;
                m_done   = cyc + 2;
            end
        end else if (!m_active && m_fin != cyc && start) begin
            m_base  = int'(base_addr) % 256;
            m_n     = int'(num_words);
            m_loop  = loop;
            m_k     = 0;
            m_pcnt  = 0;
            m_start = cyc + 1;
            if (m_n == 0) begin
                m_fin  = cyc + 1;
                m_done = cyc + 2;
            end else begin
                m_active = 1'b1;
            end
        end
    end

    function automatic bit model_idle();
        return !m_active && m_fin < cyc && m_done < cyc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting, got busy=%0b expected idle", name, busy);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t = 0;
        while (!model_idle() && t < budget) begin
            step();
            t++;
        end
        if (t >= budget) timeout(name);
    endtask

    task automatic do_start(input int b, input int n, input bit lp);
        base_addr = 16'(b);
        num_words = 16'(n);
        loop      = lp;
        start     = 1'b1;
        step();
        start     = 1'b0;
        base_addr = 16'($urandom);
        num_words = 16'($urandom);
        loop      = 1'($urandom);
    endtask

    task automatic chk_stream(input string name, input int b, input int n);
        chk({name, " count"}, acc_q.size(), n);
        for (int i = 0; i < n && i < acc_q.size(); i++)
            chk({name, " word"}, acc_q[i], (b + i) % 256);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 90000", cyc);
        $fatal(1);
    end

    initial begin
        int d0;
        int t;
        int n;
        bit lp;
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0; out_ready = 1'b0;
        base_addr = '0; num_words = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        repeat (3) step();
        rst = 1'b0;
        step();

        // basic run with literal latency and result checks
        out_ready = 1'b1;
        acc_q.delete();
        d0 = dcount;
        do_start(10, 5, 1'b0);
        chk("latency busy", busy, 1);
        step();
        chk("latency out_valid", out_valid, 1);
        chk("latency out_data", out_data, 10);
        wait_idle(50, "basic");
        chk_stream("basic", 10, 5);
        chk("basic done pulses", dcount - d0, 1);
        chk("basic pass_cnt", pass_cnt, 1);

        // backpressure 1,0,0,1,...
        acc_q.delete();
        out_ready = 1'b0;
        do_start(10, 5, 1'b0);
        t = 0;
        while (!model_idle() && t < 100) begin
            out_ready = (t % 4 == 0) || (t % 4 == 3);
            step();
            t++;
        end
        if (t >= 100) timeout("backpressure");
        chk_stream("backpressure", 10, 5);

        // address wrap
        out_ready = 1'b1;
        acc_q.delete();
        do_start(254, 4, 1'b0);
        wait_idle(50, "wrap");
        chk("wrap count", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            chk("wrap a0", acc_q[0], 254);
            chk("wrap a1", acc_q[1], 255);
            chk("wrap a2", acc_q[2], 0);
            chk("wrap a3", acc_q[3], 1);
        end

        // loop mode, 10 cycles then abort
        acc_q.delete();
        d0 = dcount;
        do_start(0, 3, 1'b1);
        repeat (10) step();
        chk("loop count", acc_q.size(), 9);
        for (int i = 0; i < 9 && i < acc_q.size(); i++) chk("loop word", acc_q[i], i % 3);
        chk("loop pass_cnt", pass_cnt, 3);
        chk("loop no done", dcount - d0, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("loop abort out_valid", out_valid, 0);
        chk("loop abort busy", busy, 0);
        chk("loop abort pass_cnt hold", pass_cnt, 3);

        // zero-length run
        acc_q.delete();
        d0 = dcount;
        do_start(5, 0, 1'b0);
        wait_idle(20, "zero");
        step();
        chk("zero done pulses", dcount - d0, 1);
        chk("zero no words", acc_q.size(), 0);

        // start during run is ignored
        acc_q.delete();
        do_start(10, 5, 1'b0);
        step();
        base_addr = 16'd100; num_words = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(50, "restart");
        chk_stream("restart", 10, 5);

        // abort after two words
        acc_q.delete();
        d0 = dcount;
        do_start(10, 5, 1'b0);
        t = 0;
        while (acc_q.size() < 2 && t < 20) begin step(); t++; end
        if (t >= 20) timeout("abort wait");
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        chk("abort no done", dcount - d0, 0);
        chk("abort busy", busy, 0);
        chk("abort pass_cnt", pass_cnt, 0);

        // reset mid-run
        do_start(20, 8, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst out_data", out_data, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst rom_addr", rom_addr, 0);
        step();

        // random runs
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            n  = (r % 10 == 0) ? 256 + int'($urandom_range(0, 60)) : int'($urandom_range(0, 12));
            lp = ($urandom_range(0, 3) == 0);
            out_ready = 1'($urandom);
            do_start(int'($urandom_range(0, 65535)), n, lp);
            t = 0;
            while (!model_idle() && t < 1000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 15) == 0);
                base_addr = 16'($urandom);
                num_words = 16'($urandom);
                loop      = 1'($urandom);
                abort     = (t > 450) || ($urandom_range(0, 199) == 0);
                step();
                t++;
            end
            start = 1'b0;
            abort = 1'b0;
            if (t >= 1000) timeout("random run");
            step();
        end

        out_ready = 1'b0;
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
